inst_loader_mem: RTL and testbench
==================================

INST_LOADER_MEM -- requirements
Module: inst_loader_mem

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit instruction words held (power of two).
REQ-002 Parameter ADDR_W, default 8, log2(DEPTH_WORDS).
REQ-003 clk_cpu  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 pc  input  32  byte address of the instruction being fetched by the CPU.
REQ-006 inst  output  32  instruction word returned for pc.
REQ-007 ld_start  input  1  one-cycle request to begin a program load.
REQ-008 ld_byte  input  8  program byte offered by the loader source.
REQ-009 ld_valid  input  1  ld_byte is valid this cycle.
REQ-010 ld_last  input  1  qualifies ld_byte as the final byte of the program.
REQ-011 ld_ready  output  1  block accepts ld_byte this cycle.
REQ-012 cpu_hold  output  1  CPU shall be held in reset while 1.
REQ-013 ld_done  output  1  one-cycle pulse when a load completes.
REQ-014 ld_err  output  1  sticky error flag for the most recent load.

Function
REQ-015 The block SHALL implement states IDLE, LOAD and RUN.
REQ-016 A byte SHALL be accepted only on a cycle with ld_valid=1 and ld_ready=1.
REQ-017 ld_ready SHALL be 1 in LOAD only, and 0 in IDLE and RUN.
REQ-018 IDLE or RUN with ld_start=1 SHALL go to LOAD next cycle, clearing word_addr, byte_cnt and ld_err.
REQ-019 ld_start in LOAD SHALL restart the load: word_addr=0, byte_cnt=0, partial word discarded, ld_err cleared.
REQ-020 Bytes SHALL be assembled little-endian: first accepted byte -> [7:0], fourth -> [31:24].
REQ-021 On the fourth byte, the assembled word SHALL be written to mem[word_addr] at that clock edge, byte_cnt SHALL return to 0, and word_addr SHALL increment.
REQ-022 When word_addr has reached DEPTH_WORDS, further completed words SHALL be discarded, memory SHALL not wrap, and ld_err SHALL be set.
REQ-023 When an accepted byte has ld_last=1 and completes a word, that word SHALL be written and the state SHALL go to RUN.
REQ-024 When an accepted byte has ld_last=1 and does not complete a word, the partial word SHALL be zero-padded in its upper bytes and written, ld_err SHALL be set, and the state SHALL go to RUN.
REQ-025 ld_done SHALL be 1 for exactly the one cycle after the last byte is accepted, coincident with the first cycle in RUN.
REQ-026 cpu_hold SHALL be 1 in IDLE and LOAD, and 0 in RUN.
REQ-027 inst SHALL be a combinational (same-cycle) read of mem[pc[ADDR_W+1:2]] in RUN, because the CPU decodes inst in the same cycle that pc is valid.
REQ-028 inst SHALL be 32'h0 (NOP) in IDLE and LOAD.
REQ-029 inst SHALL be 32'h0 in RUN when pc[1:0]!=0 or pc[31:ADDR_W+2]!=0.
REQ-030 A write and a read of the same address in the same cycle cannot occur, because reads are gated to RUN and writes to LOAD.
REQ-031 ld_valid without ld_ready (IDLE or RUN) SHALL have no effect.
REQ-032 ld_start and ld_valid in the same cycle in IDLE SHALL enter LOAD and drop the byte.

Reset
REQ-033 reset=0 SHALL immediately force state=IDLE, word_addr=0, byte_cnt=0, cpu_hold=1, ld_ready=0, ld_done=0, ld_err=0 and inst=0.
REQ-034 Memory contents SHALL NOT be cleared by reset.
REQ-035 Reset during LOAD SHALL abandon the load, and words already written SHALL remain in memory.
REQ-036 After reset release, the block SHALL stay in IDLE until ld_start.

Verification
REQ-037 Reset, then ld_start, then bytes 13 00 08 20 with ld_last on byte 4 -> mem[0]=32'h20080013; ld_done pulses one cycle; cpu_hold falls with ld_done; pc=0 gives inst=32'h20080013; ld_err=0.
REQ-038 Load 8 bytes, ld_valid toggling 1/0 each cycle -> exactly 8 bytes accepted; pc=4 gives the second word; pc=8 gives mem[2] unchanged.
REQ-039 Load 5 bytes AA BB CC DD EE with ld_last on byte 5 -> mem[1]=32'h000000EE; ld_err=1; state RUN.
REQ-040 Load 1028 bytes with DEPTH_WORDS=256 -> mem[0..255] written; 257th word discarded; mem[0] not overwritten; ld_err=1; pc=32'h400 gives inst=0.
REQ-041 reset=0 after 6 bytes of a load -> cpu_hold=1 and ld_ready=0 asynchronously; mem[0] retains the first word; a new ld_start reload overwrites from address 0.
REQ-042 In RUN, pc=32'h2 -> inst=0; ld_start then 4 bytes -> cpu_hold=1 and inst=0 during the reload; ld_err cleared at LOAD entry.

Source files
------------

// File: rtl/inst_loader_mem.sv
// Instruction memory with a byte-serial program loader.
// The block holds the CPU in reset while a program is streamed in as
// little-endian bytes, then serves instruction fetches combinationally.
//
// state | meaning
// IDLE  | no program loaded since reset; CPU held, fetches return NOP
// LOAD  | accepting program bytes into memory; CPU held, fetches return NOP
// RUN   | program loaded; CPU released, fetches read memory
module inst_loader_mem #(
   parameter int DEPTH_WORDS = 256,
   parameter int ADDR_W      = 8
) (
   input  logic        clk_cpu,
   input  logic        reset,
   input  logic [31:0] pc,
   output logic [31:0] inst,
   input  logic        ld_start,
   input  logic [7:0]  ld_byte,
   input  logic        ld_valid,
   input  logic        ld_last,
   output logic        ld_ready,
   output logic        cpu_hold,
   output logic        ld_done,
   output logic        ld_err
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t              state, state_nxt;
   // One extra bit so the address can sit at DEPTH_WORDS once memory is full
   logic [ADDR_W:0]     word_addr, word_addr_nxt;
   logic [1:0]          byte_cnt, byte_cnt_nxt;
   logic [23:0]         part, part_nxt;
   logic                err_nxt, done_nxt;
   logic                mem_we;
   logic [31:0]         wdata;
   logic                accept, word_end, full, pc_ok;
   logic [31:0]         mem [DEPTH_WORDS];

   // A restart request in LOAD takes priority; any byte offered with it is dropped
   assign accept   = (state == LOAD) && ld_valid && !ld_start;
   assign word_end = accept && ((byte_cnt == 2'd3) || ld_last);
   assign full     = word_addr[ADDR_W];

   assign ld_ready = (state == LOAD);
   assign cpu_hold = (state != RUN);

   // Assembled word: earlier bytes come from the partial register, which is
   // kept zero above the filled bytes so a short final word is zero-padded
   always_comb begin
      wdata = 32'h0;
      case (byte_cnt)
         2'd0:    wdata = {24'h0, ld_byte};
         2'd1:    wdata = {16'h0, ld_byte, part[7:0]};
         2'd2:    wdata = {8'h0, ld_byte, part[15:0]};
         default: wdata = {ld_byte, part};
      endcase
   end

   // Next-state, loader datapath and write-enable decode
   always_comb begin
      state_nxt     = state;
      word_addr_nxt = word_addr;
      byte_cnt_nxt  = byte_cnt;
      part_nxt      = part;
      err_nxt       = ld_err;
      done_nxt      = 1'b0;
      mem_we        = 1'b0;
      if (ld_start) begin
         state_nxt     = LOAD;
         word_addr_nxt = '0;
         byte_cnt_nxt  = 2'd0;
         part_nxt      = 24'h0;
         err_nxt       = 1'b0;
      end else begin
         case (state)
            LOAD: begin
               if (word_end) begin
                  byte_cnt_nxt = 2'd0;
                  part_nxt     = 24'h0;
                  if (full) begin
                     err_nxt = 1'b1;
                  end else begin
                     mem_we        = 1'b1;
                     word_addr_nxt = word_addr + 1'b1;
                  end
                  if (byte_cnt != 2'd3) err_nxt = 1'b1;
                  if (ld_last) begin
                     state_nxt = RUN;
                     done_nxt  = 1'b1;
                  end
               end else if (accept) begin
                  byte_cnt_nxt = byte_cnt + 2'd1;
                  part_nxt     = wdata[23:0];
               end
            end
            IDLE, RUN: ;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // State and loader registers
   always_ff @(posedge clk_cpu or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         word_addr <= '0;
         byte_cnt  <= 2'd0;
         part      <= 24'h0;
         ld_err    <= 1'b0;
         ld_done   <= 1'b0;
      end else begin
         state     <= state_nxt;
         word_addr <= word_addr_nxt;
         byte_cnt  <= byte_cnt_nxt;
         part      <= part_nxt;
         ld_err    <= err_nxt;
         ld_done   <= done_nxt;
      end
   end

   // Program storage survives reset so a loaded image is not lost
   always_ff @(posedge clk_cpu) begin
      if (mem_we) mem[word_addr[ADDR_W-1:0]] <= wdata;
   end

   // Same-cycle fetch; misaligned or out-of-range addresses return NOP
   assign pc_ok = (pc[1:0] == 2'b00) && ((pc >> (ADDR_W + 2)) == 32'd0);

   // Fetch path gated to RUN so a load never races a read
   always_comb begin
      inst = 32'h0;
      if (state == RUN && pc_ok) inst = mem[pc[ADDR_W+1:2]];
   end

endmodule

// File: tb/tb_inst_loader_mem.sv
// Directed bench for inst_loader_mem: program loads, error cases and reset.
module tb_inst_loader_mem;

   logic        clk_cpu = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic [31:0] inst;
   logic        ld_start;
   logic [7:0]  ld_byte;
   logic        ld_valid;
   logic        ld_last;
   logic        ld_ready;
   logic        cpu_hold;
   logic        ld_done;
   logic        ld_err;

   int n_pass = 0;
   int n_tot  = 0;

   inst_loader_mem #(.DEPTH_WORDS(256), .ADDR_W(8)) dut (
      .clk_cpu  (clk_cpu),
      .reset    (reset),
      .pc       (pc),
      .inst     (inst),
      .ld_start (ld_start),
      .ld_byte  (ld_byte),
      .ld_valid (ld_valid),
      .ld_last  (ld_last),
      .ld_ready (ld_ready),
      .cpu_hold (cpu_hold),
      .ld_done  (ld_done),
      .ld_err   (ld_err)
   );

   always #5 clk_cpu = ~clk_cpu;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
   endtask

   // Inputs change and outputs are sampled on the falling edge
   task automatic tick();
      @(negedge clk_cpu);
   endtask

   task automatic start_load();
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input logic last);
      ld_byte  = b;
      ld_valid = 1'b1;
      ld_last  = last;
      tick();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic read(input string tag, input logic [31:0] a, input logic [31:0] exp);
      pc = a;
      #1;
      check(tag, inst, exp);
   endtask

   function automatic logic [7:0] big_byte(input int i);
      logic [31:0] v;
      v = i;
      return v[7:0] ^ {5'b0, v[10:8]};
   endfunction

   initial begin
      reset = 1'b0; pc = 32'h0; ld_start = 1'b0; ld_byte = 8'h0;
      ld_valid = 1'b0; ld_last = 1'b0;
      #12;
      check("rst_hold",  {31'b0, cpu_hold}, 32'd1);
      check("rst_ready", {31'b0, ld_ready}, 32'd0);
      check("rst_done",  {31'b0, ld_done},  32'd0);
      check("rst_err",   {31'b0, ld_err},   32'd0);
      check("rst_inst",  inst, 32'h0);
      tick();
      reset = 1'b1;
      tick(); tick();

      // Bytes offered in IDLE are ignored and the block stays IDLE
      send(8'h55, 1'b1);
      check("idle_ready", {31'b0, ld_ready}, 32'd0);
      check("idle_hold",  {31'b0, cpu_hold}, 32'd1);
      check("idle_done",  {31'b0, ld_done},  32'd0);

      // Basic load; the byte offered alongside ld_start is dropped
      ld_valid = 1'b1; ld_byte = 8'hFF;
      start_load();
      ld_valid = 1'b0;
      check("load_ready", {31'b0, ld_ready}, 32'd1);
      read("load_inst_nop", 32'h0, 32'h0);
      send(8'h13, 1'b0); send(8'h00, 1'b0); send(8'h08, 1'b0); send(8'h20, 1'b1);
      check("basic_done", {31'b0, ld_done},  32'd1);
      check("basic_hold", {31'b0, cpu_hold}, 32'd0);
      check("basic_err",  {31'b0, ld_err},   32'd0);
      read("basic_pc0", 32'h0, 32'h20080013);
      tick();
      check("basic_done_1cyc", {31'b0, ld_done}, 32'd0);
      check("run_ready", {31'b0, ld_ready}, 32'd0);

      // Three full words
      start_load();
      for (int i = 0; i < 12; i++) send(8'hA0 + 8'(i), i == 11);
      read("w3_pc8", 32'h8, 32'hABAAA9A8);

      // Eight bytes with ld_valid toggling
      start_load();
      for (int i = 0; i < 8; i++) begin
         send(8'h01 + 8'(i), i == 7);
         if (i != 7) tick();
      end
      check("tog_done", {31'b0, ld_done}, 32'd1);
      read("tog_pc0", 32'h0, 32'h04030201);
      read("tog_pc4", 32'h4, 32'h08070605);
      read("tog_pc8", 32'h8, 32'hABAAA9A8);
      check("tog_err", {31'b0, ld_err}, 32'd0);

      // Short final word
      start_load();
      send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b0);
      send(8'hEE, 1'b1);
      check("short_err",  {31'b0, ld_err},   32'd1);
      check("short_hold", {31'b0, cpu_hold}, 32'd0);
      read("short_pc0", 32'h0, 32'hDDCCBBAA);
      read("short_pc4", 32'h4, 32'h000000EE);

      // Misaligned and out-of-range fetches, then a reload
      read("misalign", 32'h2, 32'h0);
      read("range", 32'h400, 32'h0);
      start_load();
      check("reload_err_clr", {31'b0, ld_err},   32'd0);
      check("reload_hold",    {31'b0, cpu_hold}, 32'd1);
      read("reload_inst", 32'h0, 32'h0);
      send(8'h44, 1'b0); send(8'h33, 1'b0); send(8'h22, 1'b0);
      read("reload_inst_mid", 32'h0, 32'h0);
      send(8'h11, 1'b1);
      read("reload_pc0", 32'h0, 32'h11223344);

      // Restart mid-load discards the partial word
      start_load();
      send(8'h77, 1'b0); send(8'h66, 1'b0);
      start_load();
      send(8'h21, 1'b0); send(8'h22, 1'b0); send(8'h23, 1'b0); send(8'h24, 1'b1);
      check("restart_err", {31'b0, ld_err}, 32'd0);
      read("restart_pc0", 32'h0, 32'h24232221);

      // Reset in the middle of a load
      start_load();
      for (int i = 0; i < 6; i++) send(8'hC0 + 8'(i), 1'b0);
      #2 reset = 1'b0;
      #1;
      check("arst_hold",  {31'b0, cpu_hold}, 32'd1);
      check("arst_ready", {31'b0, ld_ready}, 32'd0);
      check("arst_mem0",  dut.mem[0], 32'hC3C2C1C0);
      check("arst_mem1",  dut.mem[1], 32'h000000EE);
      tick();
      reset = 1'b1;
      tick(); tick();
      check("arst_idle", {31'b0, ld_ready}, 32'd0);
      start_load();
      send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b1);
      read("arst_pc0", 32'h0, 32'h04030201);
      read("arst_pc4", 32'h4, 32'h000000EE);

      // Overflow: 257 words into a 256-word memory
      start_load();
      for (int i = 0; i < 1028; i++) begin
         if (i == 1024) check("ovf_err_pre", {31'b0, ld_err}, 32'd0);
         send(big_byte(i), i == 1027);
      end
      check("ovf_done", {31'b0, ld_done}, 32'd1);
      check("ovf_err",  {31'b0, ld_err},  32'd1);
      read("ovf_pc0",   32'h0,   32'h03020100);
      read("ovf_pc200", 32'h200, 32'h01000302);
      read("ovf_pc3fc", 32'h3FC, 32'hFCFDFEFF);
      read("ovf_pc400", 32'h400, 32'h0);

      tick();
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
